// File: rtl/issue_pkg.sv
// Shared decode definitions for the issue-group former: opcode field
// positions, per-instruction decode helpers and the decoded-instruction
// record consumed by the dependency checker.
package issue_pkg;

    localparam int OP_LSB  = 2;
    localparam int OP_MSB  = 6;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int REG_W   = 5;

    typedef logic [OP_MSB-OP_LSB:0] op_t;
    typedef logic [REG_W-1:0]       reg_idx_t;

    typedef struct packed {
        logic     branch;
        logic     reg_write;
        logic     use_rs1;
        logic     use_rs2;
        logic     store;
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
    } dec_t;

    function automatic logic dec_branch(input op_t op);
        return op[4];
    endfunction

    function automatic logic dec_reg_write(input op_t op);
        return op[0] | op[2] | ~op[3];
    endfunction

    function automatic logic dec_use_rs1(input op_t op);
        return ~op[0] | (~op[3] & ~op[4]);
    endfunction

    function automatic logic dec_use_rs2(input op_t op);
        return ~op[0] & op[3];
    endfunction

    function automatic logic dec_store(input op_t op);
        return ~op[4] & op[3] & ~op[2];
    endfunction

    function automatic dec_t decode(input logic [31:0] inst);
        op_t  op;
        dec_t d;
        op          = inst[OP_MSB:OP_LSB];
        d.branch    = dec_branch(op);
        d.reg_write = dec_reg_write(op);
        d.use_rs1   = dec_use_rs1(op);
        d.use_rs2   = dec_use_rs2(op);
        d.store     = dec_store(op);
        d.rs1       = inst[RS1_LSB +: REG_W];
        d.rs2       = inst[RS2_LSB +: REG_W];
        d.rd        = inst[RD_LSB +: REG_W];
        return d;
    endfunction

endpackage

// File: rtl/issue_group_check_if.sv
// Fetch-side and decode-side signal bundle of the issue-group former.
// master: the fetch/decode environment; slave: the issue-group former.
interface issue_group_check_if #(
    parameter int ISSUE_W = 2,
    parameter int PC_W    = 13
);
    logic                    fail_predict;
    logic                    stall;
    logic                    in_valid;
    logic                    in_ready;
    logic [ISSUE_W-1:0]      in_mask;
    logic [ISSUE_W*PC_W-1:0] in_pc;
    logic [ISSUE_W*32-1:0]   in_inst;
    logic [ISSUE_W-1:0]      out_mask;
    logic [ISSUE_W*PC_W-1:0] out_pc;
    logic [ISSUE_W*32-1:0]   out_inst;
    logic [ISSUE_W-1:0]      branch_lane;

    modport master (
        output fail_predict, stall, in_valid, in_mask, in_pc, in_inst,
        input  in_ready, out_mask, out_pc, out_inst, branch_lane
    );

    modport slave (
        input  fail_predict, stall, in_valid, in_mask, in_pc, in_inst,
        output in_ready, out_mask, out_pc, out_inst, branch_lane
    );
endinterface

// File: rtl/issue_dep_pair.sv
// Pairwise hazard check: asserts block_o when the younger instruction may
// not share an issue group with the older one (RAW on a non-x0 destination,
// older is a branch, or both are stores).
module issue_dep_pair
    import issue_pkg::*;
(
    input  dec_t older_i,
    input  dec_t younger_i,
    output logic block_o
);
    logic raw_hit;
    logic unused_fields;

    assign raw_hit = older_i.reg_write && (older_i.rd != '0) &&
                     ((younger_i.use_rs1 && (younger_i.rs1 == older_i.rd)) ||
                      (younger_i.use_rs2 && (younger_i.rs2 == older_i.rd)));

    assign block_o = raw_hit || older_i.branch || (older_i.store && younger_i.store);

    // Fields that only matter in the other role of the pair.
    assign unused_fields = ^{older_i.use_rs1, older_i.use_rs2, older_i.rs1, older_i.rs2,
                             younger_i.branch, younger_i.reg_write, younger_i.rd};
endmodule

// File: rtl/issue_group_check.sv
// N-wide in-order issue-group former between fetch and decode. Fetch groups
// are queued in a circular buffer; each cycle the longest dependency-free
// in-order prefix (up to ISSUE_W) at the head is presented combinationally.
// Optional build macro ISSUE_GROUP_PERF_EN adds split_cnt/issue_cnt counters.
module issue_group_check
    import issue_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 13
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef ISSUE_GROUP_PERF_EN
    output logic [31:0] split_cnt,
    output logic [31:0] issue_cnt,
`endif
    issue_group_check_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [31:0]     inst_mem_q [DEPTH];
    logic [PC_W-1:0] pc_mem_q   [DEPTH];

    ptr_t               head_q, head_d;
    ptr_t               tail_q, tail_d;
    cnt_t               count_q, count_d;
    logic [ISSUE_W-1:0] branch_lane_q, branch_lane_d;

    logic [31:0]              cand_inst [ISSUE_W];
    logic [PC_W-1:0]          cand_pc   [ISSUE_W];
    dec_t                     cand_dec  [ISSUE_W];
    logic [ISSUE_W-1:0]       cand_valid;
    logic [ISSUE_W*ISSUE_W-1:0] blk;
    logic [ISSUE_W-1:0]       issue;
    logic [ISSUE_W-1:0]       branch_first;
    logic                     branch_found;
    logic                     in_ready;
    logic                     push_en;
    cnt_t                     pop_n, push_n;

    assign in_ready = (cnt_t'(DEPTH) - count_q) >= cnt_t'(ISSUE_W);
    assign push_en  = bus.in_valid && in_ready;

    // Gather and decode the candidate window starting at the queue head.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            cand_inst[k]  = inst_mem_q[head_q + ptr_t'(k)];
            cand_pc[k]    = pc_mem_q[head_q + ptr_t'(k)];
            cand_dec[k]   = decode(cand_inst[k]);
            cand_valid[k] = count_q > cnt_t'(k);
        end
    end

    // One hazard checker per (older, younger) pair inside the window.
    for (genvar i = 0; i < ISSUE_W; i++) begin : g_old
        for (genvar j = 0; j < ISSUE_W; j++) begin : g_yng
            if (i < j) begin : g_pair
                issue_dep_pair u_pair (
                    .older_i   (cand_dec[i]),
                    .younger_i (cand_dec[j]),
                    .block_o   (blk[i*ISSUE_W+j])
                );
            end else begin : g_none
                assign blk[i*ISSUE_W+j] = 1'b0;
            end
        end
    end

    // Prefix mask: a lane issues only if every older lane issued and no
    // older lane blocks it; also locate the first issued branch.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        issue        = '0;
        branch_first = '0;
        branch_found = 1'b0;
        issue[0]     = cand_valid[0];
        for (int j = 1; j < ISSUE_W; j++) begin
            issue[j] = issue[j-1] & cand_valid[j];
            for (int i = 0; i < j; i++) begin
                if (blk[i*ISSUE_W+j]) issue[j] = 1'b0;
            end
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            if (issue[k] && cand_dec[k].branch && !branch_found) begin
                branch_first[k] = 1'b1;
                branch_found    = 1'b1;
            end
        end
    end

    // Drive the issued lanes; unissued lanes read as zero.
    always_comb begin
        bus.out_mask = issue;
        bus.out_pc   = '0;
        bus.out_inst = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (issue[k]) begin
                bus.out_pc[k*PC_W +: PC_W] = cand_pc[k];
                bus.out_inst[k*32 +: 32]   = cand_inst[k];
            end
        end
    end

    // Lane counts for pop (issued) and push (fetched).
    always_comb begin
        pop_n  = '0;
        push_n = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            pop_n  = pop_n + cnt_t'(issue[k]);
            push_n = push_n + cnt_t'(bus.in_mask[k]);
        end
    end

    // Pointer, occupancy and branch-lane next state; flush overrides all.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        branch_lane_d = branch_lane_q;
        if (bus.fail_predict) begin
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            branch_lane_d = '0;
        end else begin
            if (push_en) begin
                tail_d  = tail_q + ptr_t'(push_n);
                count_d = count_d + push_n;
            end
            if (!bus.stall) begin
                head_d        = head_q + ptr_t'(pop_n);
                count_d       = count_d - pop_n;
                branch_lane_d = branch_first;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (RST) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            branch_lane_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            branch_lane_q <= branch_lane_d;
        end
    end

    // Queue storage write at the tail for each valid fetch lane.
    always_ff @(posedge CLK) begin
        // NOTE: storage is not reset; entries are only read once count covers them.
        if (push_en && !bus.fail_predict) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (bus.in_mask[k]) begin
                    inst_mem_q[tail_q + ptr_t'(k)] <= bus.in_inst[k*32 +: 32];
                    pc_mem_q[tail_q + ptr_t'(k)]   <= bus.in_pc[k*PC_W +: PC_W];
                end
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.branch_lane = branch_lane_q;

`ifdef ISSUE_GROUP_PERF_EN
    logic [31:0] split_cnt_q;
    logic [31:0] issue_cnt_q;
    cnt_t        cand_n;

    assign cand_n = (count_q < cnt_t'(ISSUE_W)) ? count_q : cnt_t'(ISSUE_W);

    // Performance counters: issued lanes and dependency-split groups.
    always_ff @(posedge CLK) begin
        if (RST) begin
            split_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else if (!bus.stall) begin
            issue_cnt_q <= issue_cnt_q + 32'(pop_n);
            if ((count_q >= cnt_t'(2)) && (pop_n < cand_n)) split_cnt_q <= split_cnt_q + 32'd1;
        end
    end

    assign split_cnt = split_cnt_q;
    assign issue_cnt = issue_cnt_q;
`endif
endmodule

// File: tb/tb_issue_group_check.sv
// Scoreboard bench for issue_group_check (ISSUE_W=2, DEPTH=8, PC_W=13).
// A queue-based reference model predicts each cycle's presented group,
// registered branch lane and in_ready; a negedge monitor compares.
module tb_issue_group_check;
    localparam int W   = 2;
    localparam int D   = 8;
    localparam int PCW = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;

    issue_group_check_if #(.ISSUE_W(W), .PC_W(PCW)) bus ();

`ifdef ISSUE_GROUP_PERF_EN
    logic [31:0] split_cnt;
    logic [31:0] issue_cnt;
`endif

    issue_group_check #(.ISSUE_W(W), .DEPTH(D), .PC_W(PCW)) dut (
        .CLK       (clk),
        .RST       (rst),
`ifdef ISSUE_GROUP_PERF_EN
        .split_cnt (split_cnt),
        .issue_cnt (issue_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     mask;
        logic [W*PCW-1:0] pc;
        logic [W*32-1:0]  inst;
        logic [W-1:0]     bl;
        logic             rdy;
    } exp_t;

    exp_t            exp_q[$];
    logic [PCW-1:0]  m_pc[$];
    logic [31:0]     m_inst[$];
    logic [W-1:0]    m_bl   = '0;
    logic [PCW-1:0]  pc_ctr = 13'h100;
    logic [6:0]      ops [7] = '{7'h13, 7'h33, 7'h63, 7'h23, 7'h03, 7'h37, 7'h6F};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    endtask

    // True when the younger instruction may not join a group behind the older.
    function automatic logic blocks(input logic [31:0] o, input logic [31:0] y);
        logic [4:0] oo, yo;
        logic       o_wr, y_rs1, y_rs2, o_st, y_st;
        oo    = o[6:2];
        yo    = y[6:2];
        o_wr  = oo[0] | oo[2] | ~oo[3];
        y_rs1 = ~yo[0] | (~yo[3] & ~yo[4]);
        y_rs2 = ~yo[0] & yo[3];
        o_st  = ~oo[4] & oo[3] & ~oo[2];
        y_st  = ~yo[4] & yo[3] & ~yo[2];
        return oo[4] || (o_st && y_st) ||
               (o_wr && (o[11:7] != 5'd0) &&
                ((y_rs1 && (y[19:15] == o[11:7])) || (y_rs2 && (y[24:20] == o[11:7]))));
    endfunction

    // Number of entries from the model queue head forming the next group.
    function automatic int model_len();
        int lim;
        lim = (m_inst.size() < W) ? m_inst.size() : W;
        for (int j = 0; j < lim; j++)
            for (int i = 0; i < j; i++)
                if (blocks(m_inst[i], m_inst[j])) return j;
        return lim;
    endfunction

    // One cycle: record expectation for the current state, drive inputs,
    // then advance the model to the state after the coming edge.
    task automatic step(input logic r, input logic fp, input logic st, input logic v,
                        input logic [W-1:0] m, input logic [31:0] i0, input logic [31:0] i1);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        n      = model_len();
        e.mask = '0;
        e.pc   = '0;
        e.inst = '0;
        for (int k = 0; k < n; k++) begin
            e.mask[k]            = 1'b1;
            e.pc[k*PCW +: PCW]   = m_pc[k];
            e.inst[k*32 +: 32]   = m_inst[k];
        end
        e.bl  = m_bl;
        e.rdy = (D - m_inst.size()) >= W;
        exp_q.push_back(e);

        rst              = r;
        bus.fail_predict = fp;
        bus.stall        = st;
        bus.in_valid     = v;
        bus.in_mask      = m;
        bus.in_inst      = {i1, i0};
        bus.in_pc        = {pc_ctr + 13'd4, pc_ctr};

        if (r || fp) begin
            m_inst.delete();
            m_pc.delete();
            m_bl = '0;
        end else begin
            if (!st) begin
                m_bl = '0;
                for (int k = 0; k < n; k++)
                    if (m_inst[k][6] && (m_bl == '0)) m_bl[k] = 1'b1;
                for (int k = 0; k < n; k++) begin
                    void'(m_inst.pop_front());
                    void'(m_pc.pop_front());
                end
            end
            if (v && e.rdy) begin
                if (m[0]) begin m_inst.push_back(i0); m_pc.push_back(pc_ctr); end
                if (m[1]) begin m_inst.push_back(i1); m_pc.push_back(pc_ctr + 13'd4); end
                pc_ctr = pc_ctr + 13'd4 * 13'(m[0] + m[1]);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] rd, rs1, rs2;
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        return {7'd0, rs2, rs1, 3'd0, rd, ops[$urandom_range(0, 6)]};
    endfunction

    // Monitor: compare everything the DUT presents this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin : mon
            exp_t e;
            e = exp_q.pop_front();
            check("out_mask", 64'(bus.out_mask), 64'(e.mask));
            check("out_pc", 64'(bus.out_pc), 64'(e.pc));
            check("out_inst", 64'(bus.out_inst), 64'(e.inst));
            check("branch_lane", 64'(bus.branch_lane), 64'(e.bl));
            check("in_ready", 64'(bus.in_ready), 64'(e.rdy));
        end
    end

    initial begin
        bus.fail_predict = 1'b0;
        bus.stall        = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_mask      = '0;
        bus.in_pc        = '0;
        bus.in_inst      = '0;

        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle(1);

        // independent pair
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00500093, 32'h00100193);
        idle(2);
        // RAW split
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00500093, 32'h00108133);
        idle(3);
        // x0 destination does not create a dependency
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00000013, 32'h00000133);
        idle(2);
        // branch closes the group
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00000463, 32'h00100193);
        idle(3);
        // two stores never pair
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00102023, 32'h00202223);
        idle(3);

        // fill under stall, attempt an extra push while full, then drain
        for (int g = 0; g < 5; g++)
            step(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 32'h00500093, 32'h00100193);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
        // keep pushing while draining so the tail wraps again
        for (int g = 0; g < 6; g++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00500093, 32'h00100193);
        idle(6);

        // flush with simultaneous push and stall
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00000463, 32'h00100193);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h00500093, 32'h00100193);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 32'h00500093, 32'h00100193);
        idle(2);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin : rnd
            logic [W-1:0] m;
            int           ms;
            ms = $urandom_range(0, 3);
            m  = (ms == 0) ? 2'b00 : ((ms == 1) ? 2'b01 : 2'b11);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 m, rand_inst(), rand_inst());
        end
        idle(4);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/issue_group_check.md
Name: issue_group_check

Overview:
- Parametrised N-wide in-order issue-group former between fetch and decode.
- Buffers fetched instructions in a circular queue.
- Each cycle, issues the longest dependency-free in-order prefix (up to ISSUE_W instructions) from the queue head.
- Records the lane of the first branch in the issued group for the D-stage PC calculator.

Parameters:
ISSUE_W, 2, lanes per fetch and issue group (1..4)
DEPTH, 8, queue entries; power of two, >= 2*ISSUE_W
PC_W, 13, PC width

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
fail_predict  in  1  flush: empties queue, clears branch_lane
stall  in  1  downstream hold: no pop, branch_lane held
in_valid  in  1  fetch group valid
in_ready  out  1  queue has >= ISSUE_W free entries
in_mask  in  ISSUE_W  valid lanes; contiguous from lane 0
in_pc  in  ISSUE_W*PC_W  lane i at [i*PC_W +: PC_W]
in_inst  in  ISSUE_W*32  lane i at [i*32 +: 32]
out_mask  out  ISSUE_W  issued lanes; contiguous from lane 0
out_pc  out  ISSUE_W*PC_W  issued PCs; unissued lanes 0
out_inst  out  ISSUE_W*32  issued insts; unissued lanes 32'd0
branch_lane  out  ISSUE_W  registered one-hot lane of first branch in last issued group; 0 if none

Behaviour:
- Decode per inst (op = inst[6:2]):
  - branch = op[4]
  - reg_write = op[0] | op[2] | ~op[3]
  - use_rs1 = ~op[0] | (~op[3] & ~op[4])
  - use_rs2 = ~op[0] & op[3]
  - store = ~op[4] & op[3] & ~op[2]
  - rs1 = [19:15], rs2 = [24:20], rd = [11:7]
- Candidates: queue entries head+0 .. head+min(count, ISSUE_W)-1. Candidate j issues only if every candidate i < j issues and none of these hold:
  - i reg_write, rd_i != 0, and (use_rs1_j & rs1_j == rd_i or use_rs2_j & rs2_j == rd_i)
  - i is a branch (a branch always closes the group)
  - i and j are both stores
- Lane 0 always issues when count > 0. The group outputs are combinational from queue state, with zero added cycles; an instruction pushed at edge t is visible from cycle t+1.
- Pop: at the edge, if !stall, head advances by popcount(out_mask). If stall, head is unchanged and the outputs are re-presented.
- Push: in_valid & in_ready writes the in_mask lanes at the tail; tail advances by popcount(in_mask). in_valid with in_mask == 0 is a no-op.
- in_ready = (DEPTH - count) >= ISSUE_W, evaluated on the registered count; push and pop in the same cycle are both honoured.
- Pointers wrap modulo DEPTH. count is clog2(DEPTH)+1 bits, so the full queue is distinguishable from the empty one.
- branch_lane: at each !stall edge, loads the one-hot lane of the first issued instruction with op[4]=1, else 0. Held on stall.
- Reset or fail_predict (fail_predict has priority over push, pop and stall): head = tail = count = 0, branch_lane = 0, and any same-cycle push is dropped.
- Reset values: in_ready = 1, out_mask = 0, out_pc = 0, out_inst = 0, branch_lane = 0.
- Empty queue: out_mask = 0, all outputs zero.
- Queue storage itself needs no reset.

Optional Feature:
- Macro: ISSUE_GROUP_PERF_EN.
- Defined:
  - Adds output split_cnt [31:0]: increments at each !stall edge where count >= 2 and popcount(out_mask) < min(count, ISSUE_W), i.e. a dependency split the group.
  - Adds output issue_cnt [31:0]: accumulates popcount(out_mask) on !stall.
  - Both counters clear on RST only (not on fail_predict) and wrap at 2^32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package issue_pkg: opcode-field bit positions, the decode helper functions (branch/reg_write/use_rs1/use_rs2/store), and a decoded-instruction struct typedef.
- Sub-module issue_dep_pair: combinational check of one (older, younger) instruction pair → block bit. Instantiated for every i < j within the group; the top level ANDs these into the prefix mask.

Test Plan:
- Independent pair: push 0x00500093 (addi x1,x0,5) and 0x00100193 (addi x3,x0,1), mask 2'b11 → next cycle out_mask = 2'b11, branch_lane = 0 after the issue edge.
- RAW: push 0x00500093 and 0x00108133 (add x2,x1,x1) → cycle 1 out_mask = 2'b01 with lane1 inst = 0, pc = 0; cycle 2 add issues alone in lane 0.
- rd = x0 exemption: push 0x00000013 (addi x0,x0,0) and 0x00000133 (add x2,x0,x0) → out_mask = 2'b11.
- Branch and stores:
  - Push 0x00000463 (beq) and 0x00100193 → out_mask = 2'b01, branch_lane = 2'b01 after the edge.
  - Push 0x00102023 (sw) and 0x00202223 (sw) → issued as two single groups.
- Full/stall/wrap:
  - Push 4 groups with stall = 1 (DEPTH = 8) → count = 8, in_ready = 0.
  - Release stall → pops 2 per cycle, in_ready = 1 after the first pop.
  - Tail wraps, and PC order is preserved across the wrap.
- Flush: fail_predict = 1 together with in_valid = 1 and stall = 1 → next cycle count = 0, out_mask = 0, branch_lane = 0, pushed group dropped.
